wb_test_status: RTL and testbench

- Wishbone slave in the user project area that reports firmware test progress and result on mprj_io[1:0].
- The Caravel-level bench waits for these pins: 2'b00 means SoC initialised; bit0 high means done; bit1 high means fail.
- Firmware drives the phases through register writes.
- A watchdog forces a FAIL verdict if firmware hangs, so simulations always terminate.

---
 rtl/wb_test_status_pkg.sv | 36 +++
 rtl/wb_test_status_wdt.sv | 49 ++++
 rtl/wb_test_status.sv | 143 ++++++++++++++
 tb/tb_wb_test_status.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_test_status_pkg.sv
// Shared types and constants for the wb_test_status Wishbone status reporter.
// State encodings double as the STATUS[1:0] field seen by firmware.
package wb_test_status_pkg;

   typedef enum logic [1:0] {
      ST_BOOT    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PASS    = 2'd2,
      ST_FAIL    = 2'd3
   } state_e;

   localparam logic [3:0] REG_CTRL      = 4'h0;
   localparam logic [3:0] REG_WDT_LOAD  = 4'h4;
   localparam logic [3:0] REG_STATUS    = 4'h8;
   localparam logic [3:0] REG_WDT_COUNT = 4'hC;

   localparam int CTRL_START = 0;
   localparam int CTRL_DONE  = 1;
   localparam int CTRL_FAIL  = 2;

   localparam logic [1:0] IO_BOOT    = 2'b11;
   localparam logic [1:0] IO_RUNNING = 2'b00;
   localparam logic [1:0] IO_PASS    = 2'b01;
   localparam logic [1:0] IO_FAIL    = 2'b11;

   function automatic logic [1:0] io_pattern(input state_e s);
      case (s)
         ST_BOOT:    io_pattern = IO_BOOT;
         ST_RUNNING: io_pattern = IO_RUNNING;
         ST_PASS:    io_pattern = IO_PASS;
         ST_FAIL:    io_pattern = IO_FAIL;
         default:    io_pattern = IO_FAIL;
      endcase
   endfunction

endpackage

// File: rtl/wb_test_status_wdt.sv
// Loadable watchdog down-counter; expire_o pulses combinationally on the 1 -> 0 step.
// A reload in the same cycle suppresses expiry; the count parks at zero.
module wb_test_status_wdt
   import wb_test_status_pkg::*;
#(
   parameter int                 WIDTH     = 24,
   parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             reload_i,
   input  logic [WIDTH-1:0] reload_val_i,
   output logic [WIDTH-1:0] count_o,
   output logic             expire_o
);

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count and expiry pulse
   always_comb begin
      count_d  = count_q;
      expire_o = 1'b0;
      if (reload_i) begin
         count_d = reload_val_i;
      end else if (en_i && (count_q != CNT_ZERO)) begin
         count_d  = count_q - CNT_ONE;
         expire_o = (count_q == CNT_ONE);
      end else begin
         count_d = count_q;
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= RESET_VAL;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/wb_test_status.sv
// Wishbone slave reporting firmware test progress on mprj_io[1:0], with a watchdog
// that forces a FAIL verdict if firmware stalls in RUNNING.
module wb_test_status
   import wb_test_status_pkg::*;
#(
   parameter logic [31:0]          BASE_ADDR     = 32'h3000_0100,
   parameter int                   WDT_WIDTH     = 24,
   parameter logic [WDT_WIDTH-1:0] WDT_RESET_VAL = 24'hFF_FFFF
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [1:0]  io_out,
   output logic [1:0]  io_oeb
);

   state_e                 state_q, state_d;
   logic                   expired_q, expired_d;
   logic                   ack_q, ack_d;
   logic [31:0]            dat_q, dat_d;
   logic [1:0]             io_q, io_d;
   logic [WDT_WIDTH-1:0]   wdt_load_q, wdt_load_d;

   logic                   sel_s, wr_s, ctrl_wr_s, load_wr_s, start_s;
   logic [3:0]             off_s;
   logic                   wdt_en_s, wdt_reload_s, wdt_expire_s;
   logic [WDT_WIDTH-1:0]   wdt_reload_val_s, wdt_count_s;
   logic                   unused_s;

   assign sel_s     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign ack_d     = sel_s & ~ack_q;
   assign wr_s      = ack_d & wbs_we_i;
   assign off_s     = {wbs_adr_i[3:2], 2'b00};
   assign ctrl_wr_s = wr_s & (off_s == REG_CTRL) & wbs_sel_i[0];
   assign load_wr_s = wr_s & (off_s == REG_WDT_LOAD);
   assign start_s   = (state_q == ST_BOOT) & ctrl_wr_s & wbs_dat_i[CTRL_START];
   assign unused_s  = ^{wbs_adr_i[1:0], wbs_dat_i[31:WDT_WIDTH], wbs_sel_i[3]};

   // A WDT_LOAD write reloads the counter with the freshly written value.
   assign wdt_en_s         = (state_q == ST_RUNNING) & (wdt_load_q != {WDT_WIDTH{1'b0}});
   assign wdt_reload_s     = load_wr_s | start_s;
   assign wdt_reload_val_s = load_wr_s ? wdt_load_d : wdt_load_q;

   wb_test_status_wdt #(
      .WIDTH     (WDT_WIDTH),
      .RESET_VAL (WDT_RESET_VAL)
   ) u_wdt (
      .clk          (wb_clk_i),
      .rst          (wb_rst_i),
      .en_i         (wdt_en_s),
      .reload_i     (wdt_reload_s),
      .reload_val_i (wdt_reload_val_s),
      .count_o      (wdt_count_s),
      .expire_o     (wdt_expire_s)
   );

   // Byte-lane merge for WDT_LOAD
   always_comb begin
      wdt_load_d = wdt_load_q;
      for (int i = 0; i < WDT_WIDTH; i++) begin
         if (load_wr_s && wbs_sel_i[i/8]) begin
            wdt_load_d[i] = wbs_dat_i[i];
         end else begin
            wdt_load_d[i] = wdt_load_q[i];
         end
      end
   end

   // Test-phase FSM; expiry takes priority over a simultaneous DONE write
   always_comb begin
      state_d   = state_q;
      expired_d = expired_q;
      case (state_q)
         ST_BOOT: begin
            if (start_s) begin
               state_d = ST_RUNNING;
            end else begin
               state_d = ST_BOOT;
            end
         end
         ST_RUNNING: begin
            if (wdt_expire_s) begin
               state_d   = ST_FAIL;
               expired_d = 1'b1;
            end else if (ctrl_wr_s && wbs_dat_i[CTRL_DONE]) begin
               state_d = wbs_dat_i[CTRL_FAIL] ? ST_FAIL : ST_PASS;
            end else begin
               state_d = ST_RUNNING;
            end
         end
         default: state_d = state_q;
      endcase
      io_d = io_pattern(state_d);
   end

   // Read mux, driven only in the ack cycle
   always_comb begin
      dat_d = 32'h0;
      if (ack_d) begin
         case (off_s)
            REG_CTRL:      dat_d = 32'h0;
            REG_WDT_LOAD:  dat_d = {{(32-WDT_WIDTH){1'b0}}, wdt_load_q};
            REG_STATUS:    dat_d = {28'h0, (state_q == ST_FAIL), expired_q, state_q};
            REG_WDT_COUNT: dat_d = {{(32-WDT_WIDTH){1'b0}}, wdt_count_s};
            default:       dat_d = 32'h0;
         endcase
      end else begin
         dat_d = 32'h0;
      end
   end

   // State and bus registers
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_BOOT;
         expired_q  <= 1'b0;
         ack_q      <= 1'b0;
         dat_q      <= 32'h0;
         io_q       <= IO_BOOT;
         wdt_load_q <= WDT_RESET_VAL;
      end else begin
         state_q    <= state_d;
         expired_q  <= expired_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         io_q       <= io_d;
         wdt_load_q <= wdt_load_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign io_out    = io_q;
   assign io_oeb    = 2'b00;

endmodule

// File: tb/tb_wb_test_status.sv
// Self-checking bench for wb_test_status: directed vector table, hand-written
// timing sequences, and randomized traffic checked against a reference model.
module tb_wb_test_status;

   localparam logic [31:0] BASE = 32'h3000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic        ack;
   logic [31:0] rdat;
   logic [1:0]  io_out, io_oeb;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: phase, watchdog reload value, remaining count, expired flag
   logic [1:0]  m_state;
   logic [31:0] m_load, m_cnt;
   logic        m_exp;

   always #5 clk = ~clk;

   wb_test_status dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_adr_i (adr),
      .wbs_dat_i (wdat),
      .wbs_ack_o (ack),
      .wbs_dat_o (rdat),
      .io_out    (io_out),
      .io_oeb    (io_oeb)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [1:0] m_io();
      case (m_state)
         2'd0:    return 2'b11;
         2'd1:    return 2'b00;
         2'd2:    return 2'b01;
         default: return 2'b11;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [3:0] off);
      case (off)
         4'h4:    return m_load;
         4'h8:    return {28'd0, (m_state == 2'd3), m_exp, m_state};
         4'hC:    return m_cnt;
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      m_state = 2'd0;
      m_load  = 32'h00FF_FFFF;
      m_cnt   = 32'h00FF_FFFF;
      m_exp   = 1'b0;
   endtask

   // One clock edge of the model; wr says whether a write is acknowledged at this edge
   task automatic m_step(input bit wr, input logic [3:0] off, input logic [31:0] d,
                         input logic [3:0] s);
      bit          ctrl_wr, load_wr, counting, expire;
      logic [31:0] nl;
      ctrl_wr  = wr && (off == 4'h0) && s[0];
      load_wr  = wr && (off == 4'h4);
      counting = (m_state == 2'd1) && (m_load != 32'd0);
      expire   = counting && (m_cnt == 32'd1) && !load_wr;
      if (load_wr) begin
         nl = m_load;
         for (int b = 0; b < 3; b++)
            if (s[b]) nl = (nl & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
         m_load = nl;
         m_cnt  = nl;
      end else if (counting && m_cnt != 32'd0) begin
         m_cnt = m_cnt - 32'd1;
      end
      case (m_state)
         2'd0: if (ctrl_wr && d[0]) begin m_state = 2'd1; m_cnt = m_load; end
         2'd1: begin
            if (expire) begin m_state = 2'd3; m_exp = 1'b1; end
            else if (ctrl_wr && d[1]) m_state = d[2] ? 2'd3 : 2'd2;
         end
         default: ;
      endcase
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); m_step(1'b0, 4'h0, 32'd0, 4'h0); #1;
         check("idle_io", {30'd0, io_out}, {30'd0, m_io()});
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
      sel = 4'h0; adr = 32'd0; wdat = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_reset();
   endtask

   // Single Wishbone transaction; starts and ends 1 time unit after a rising edge
   task automatic xact(input bit w, input logic [3:0] off, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
      logic [31:0] exp_rd;
      exp_rd = m_read(off);
      stb = 1'b1; cyc = 1'b1; we = w; adr = BASE + {28'd0, off}; wdat = d; sel = s;
      @(posedge clk); m_step(w, off, d, s); #1;
      check("ack", {31'd0, ack}, 32'd1);
      rd = rdat;
      if (!w) check("rdata_model", rdat, exp_rd);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      @(posedge clk); m_step(1'b0, 4'h0, 32'd0, 4'h0); #1;
      check("ack_low", {31'd0, ack}, 32'd0);
      check("dat_idle", rdat, 32'd0);
      check("io_model", {30'd0, io_out}, {30'd0, m_io()});
   endtask

   typedef struct {
      int          op;      // 0 reset, 1 write, 2 read, 3 idle 10
      logic [3:0]  off;
      logic [31:0] data;
      logic [3:0]  sel;
      logic [31:0] exp_rd;
      logic [1:0]  exp_io;
   } vec_t;

   vec_t vecs[24];

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int          n, acks;
      logic [3:0]  pat;

      vecs[0]  = '{0, 4'h0, 32'h0,         4'h0, 32'h0,         2'b11};
      vecs[1]  = '{3, 4'h0, 32'h0,         4'h0, 32'h0,         2'b11};
      vecs[2]  = '{2, 4'h8, 32'h0,         4'hF, 32'h0,         2'b11};
      vecs[3]  = '{2, 4'h4, 32'h0,         4'hF, 32'h00FF_FFFF, 2'b11};
      vecs[4]  = '{2, 4'h0, 32'h0,         4'hF, 32'h0,         2'b11};
      vecs[5]  = '{1, 4'h0, 32'h1,         4'hF, 32'h0,         2'b00};
      vecs[6]  = '{1, 4'h0, 32'h2,         4'hF, 32'h0,         2'b01};
      vecs[7]  = '{2, 4'h8, 32'h0,         4'hF, 32'h2,         2'b01};
      vecs[8]  = '{1, 4'h0, 32'h6,         4'hF, 32'h0,         2'b01};
      vecs[9]  = '{2, 4'h8, 32'h0,         4'hF, 32'h2,         2'b01};
      vecs[10] = '{1, 4'h4, 32'hAABB_CCDD, 4'h1, 32'h0,         2'b01};
      vecs[11] = '{2, 4'h4, 32'h0,         4'hF, 32'h00FF_FFDD, 2'b01};
      vecs[12] = '{0, 4'h0, 32'h0,         4'h0, 32'h0,         2'b11};
      vecs[13] = '{1, 4'h0, 32'h1,         4'hF, 32'h0,         2'b00};
      vecs[14] = '{1, 4'h0, 32'h6,         4'hF, 32'h0,         2'b11};
      vecs[15] = '{2, 4'h8, 32'h0,         4'hF, 32'hB,         2'b11};
      vecs[16] = '{0, 4'h0, 32'h0,         4'h0, 32'h0,         2'b11};
      vecs[17] = '{1, 4'h0, 32'h6,         4'hF, 32'h0,         2'b11};
      vecs[18] = '{1, 4'h0, 32'h7,         4'hE, 32'h0,         2'b11};
      vecs[19] = '{2, 4'h8, 32'h0,         4'hF, 32'h0,         2'b11};
      vecs[20] = '{1, 4'h0, 32'h7,         4'h1, 32'h0,         2'b00};
      vecs[21] = '{1, 4'h0, 32'h4,         4'hF, 32'h0,         2'b00};
      vecs[22] = '{2, 4'h8, 32'h0,         4'hF, 32'h1,         2'b00};
      vecs[23] = '{2, 4'h4, 32'h0,         4'hF, 32'h00FF_FFFF, 2'b00};

      for (int i = 0; i < 24; i++) begin
         case (vecs[i].op)
            0: begin
               do_reset();
               check("rst_ack", {31'd0, ack}, 32'd0);
               check("rst_dat", rdat, 32'd0);
               check("rst_oeb", {30'd0, io_oeb}, 32'd0);
            end
            1: xact(1'b1, vecs[i].off, vecs[i].data, vecs[i].sel, rd);
            2: begin
               xact(1'b0, vecs[i].off, 32'd0, vecs[i].sel, rd);
               check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            end
            default: idle(10);
         endcase
         check($sformatf("vec%0d_io", i), {30'd0, io_out}, {30'd0, vecs[i].exp_io});
      end

      // Watchdog expiry lands exactly 5 edges after the START ack edge
      do_reset();
      xact(1'b1, 4'h4, 32'd5, 4'hF, rd);
      xact(1'b1, 4'h0, 32'd1, 4'hF, rd);
      n = 1;
      while (io_out !== 2'b11 && n < 20) begin idle(1); n++; end
      check("wdt_cycles", n, 5);
      xact(1'b0, 4'h8, 32'd0, 4'hF, rd);  check("wdt_status", rd, 32'hF);
      xact(1'b0, 4'hC, 32'd0, 4'hF, rd);  check("wdt_count", rd, 32'd0);

      // DONE write coinciding with expiry: expiry wins
      do_reset();
      xact(1'b1, 4'h4, 32'd2, 4'hF, rd);
      xact(1'b1, 4'h0, 32'd1, 4'hF, rd);
      xact(1'b1, 4'h0, 32'd2, 4'hF, rd);
      xact(1'b0, 4'h8, 32'd0, 4'hF, rd);  check("expire_vs_done", rd, 32'hF);

      // WDT_LOAD write coinciding with expiry: reload wins
      do_reset();
      xact(1'b1, 4'h4, 32'd2, 4'hF, rd);
      xact(1'b1, 4'h0, 32'd1, 4'hF, rd);
      xact(1'b1, 4'h4, 32'd3, 4'hF, rd);
      xact(1'b0, 4'h8, 32'd0, 4'hF, rd);  check("reload_vs_expire", rd, 32'h1);

      // Out-of-window address: never acknowledged
      do_reset();
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); m_step(1'b0, 4'h0, 32'd0, 4'h0); #1;
         if (ack) acks++;
      end
      check("bad_addr_acks", acks, 0);

      // Held strobe: ack pulses every other cycle
      adr = BASE + 32'h8;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); m_step(1'b0, 4'h0, 32'd0, 4'h0); #1;
         pat[3-i] = ack;
      end
      check("b2b_pattern", {28'd0, pat}, 32'hA);
      stb = 1'b0; cyc = 1'b0;
      idle(1);

      // Reset during an ack cycle while in PASS
      xact(1'b1, 4'h0, 32'd1, 4'hF, rd);
      xact(1'b1, 4'h0, 32'd2, 4'hF, rd);
      check("pass_io", {30'd0, io_out}, 32'd1);
      stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h8;
      @(posedge clk); m_step(1'b0, 4'h0, 32'd0, 4'h0); #1;
      check("pre_rst_ack", {31'd0, ack}, 32'd1);
      rst = 1'b1;
      #1;
      m_reset();
      check("rst_ack_drop", {31'd0, ack}, 32'd0);
      check("rst_io", {30'd0, io_out}, 32'h3);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); m_step(1'b0, 4'h0, 32'd0, 4'h0); #1;
      check("reserve_ack", {31'd0, ack}, 32'd1);
      check("reserve_status", rdat, 32'd0);
      stb = 1'b0; cyc = 1'b0;
      idle(1);

      // Randomized traffic against the model
      for (int ep = 0; ep < 4; ep++) begin
         do_reset();
         for (int k = 0; k < 60; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 2)
               xact(1'b1, 4'h0, 32'($urandom_range(0, 7)), 4'($urandom_range(0, 15)) | 4'(r == 0), rd);
            else if (r == 3)
               xact(1'b1, 4'h4, (k[0] ? $urandom : 32'($urandom_range(0, 12))),
                    (k[0] ? 4'($urandom_range(0, 15)) : 4'hF), rd);
            else if (r <= 6)
               xact(1'b0, {2'($urandom_range(0, 3)), 2'b00}, 32'd0, 4'hF, rd);
            else
               idle($urandom_range(1, 6));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
